// File: rtl/etapa_pipe_hs.sv
// Multi-lane valid/ready pipeline stage with bubble collapsing and occupancy count.
// Optional idle-symbol fill of invalid output data: define ETAPA_PIPE_IDLE_FILL_EN.
module etapa_pipe_hs #(
  parameter int              WIDTH     = 8,
  parameter int              LANES     = 4,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'hBC
) (
  input  logic                           clk_8f,
  input  logic                           reset,
  input  logic [LANES*WIDTH-1:0]         data_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic [LANES*WIDTH-1:0]         data_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int W  = LANES * WIDTH;
  localparam int OW = $clog2(DEPTH + 1);
`ifdef ETAPA_PIPE_IDLE_FILL_EN
  localparam bit IDLE_FILL = 1'b1;
`else
  localparam bit IDLE_FILL = 1'b0;
`endif

  logic [W-1:0]     d_reg [DEPTH];
  logic [DEPTH-1:0] v_reg;
  logic [OW-1:0]    occ_reg;
  logic [DEPTH-1:0] adv;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance if any stage at or downstream of it has room to move.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = ready_in | ~v_reg[DEPTH-1];
    adv[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry  = carry | ~v_reg[i];
      adv[i] = carry;
    end
  end

  assign ready_out = adv[0] & reset;
  assign in_xfer   = valid_in & ready_out;
  assign out_xfer  = v_reg[DEPTH-1] & ready_in;

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= '0;
      end
      v_reg   <= '0;
      occ_reg <= '0;
    end else begin
      if (adv[0]) begin
        d_reg[0] <= data_in;
        v_reg[0] <= valid_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          d_reg[i] <= d_reg[i-1];
          v_reg[i] <= v_reg[i-1];
        end
      end
      if (in_xfer && !out_xfer) begin
        occ_reg <= occ_reg + OW'(1);
      end else if (out_xfer && !in_xfer) begin
        occ_reg <= occ_reg - OW'(1);
      end
    end
  end

  assign valid_out = v_reg[DEPTH-1];
  assign occupancy = occ_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign data_out[gi*WIDTH +: WIDTH] = (IDLE_FILL && !v_reg[DEPTH-1]) ?
                                           IDLE_WORD : d_reg[DEPTH-1][gi*WIDTH +: WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_etapa_pipe_hs.sv
// Randomized and directed bench for etapa_pipe_hs against a slot/queue reference model.
module tb_etapa_pipe_hs;

  localparam int DEPTH = 2;
  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam logic [31:0] IDLE_VEC = 32'hBCBC_BCBC;

  logic        clk_8f = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  // Reference: DEPTH slots, each possibly empty; plus a queue of accepted words in order.
  logic        mv [DEPTH];
  logic [31:0] md [DEPTH];
  logic [31:0] exp_q [$];

  etapa_pipe_hs #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .IDLE_WORD(8'hBC)) dut (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .occupancy(occupancy)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic rdy, input string ph);
    logic hole;
    int   h;
    @(negedge clk_8f);
    reset = r; valid_in = v; data_in = d; ready_in = rdy;
    #1;
    hole = (mv[DEPTH-1] && rdy);
    for (int i = 0; i < DEPTH; i++) if (!mv[i]) hole = 1'b1;
    check_eq({ph, ":valid_out"}, 64'(valid_out), 64'(mv[DEPTH-1]));
    check_eq({ph, ":occupancy"}, 64'(occupancy), 64'(exp_q.size()));
    check_eq({ph, ":ready_out"}, 64'(ready_out), 64'(r && hole));
    if (mv[DEPTH-1] && exp_q.size() > 0)
      check_eq({ph, ":data_order"}, 64'(data_out), 64'(exp_q[0]));
    else if (!mv[DEPTH-1]) begin
`ifdef ETAPA_PIPE_IDLE_FILL_EN
      check_eq({ph, ":idle_data"}, 64'(data_out), 64'(IDLE_VEC));
`else
      check_eq({ph, ":bubble_data"}, 64'(data_out), 64'(md[DEPTH-1]));
`endif
    end
    $display("%s: r=%0b vin=%0b din=%h rdy=%0b | vout=%0b dout=%h rout=%0b occ=%0d",
             ph, r, v, d, rdy, valid_out, data_out, ready_out, occupancy);

    if (!r) begin
      for (int i = 0; i < DEPTH; i++) begin mv[i] = 1'b0; md[i] = '0; end
      exp_q.delete();
    end else begin
      if (mv[DEPTH-1] && rdy) void'(exp_q.pop_front());
      // Furthest-downstream free slot; everything upstream of it moves one step.
      h = -1;
      for (int i = 0; i < DEPTH; i++)
        if (!mv[i] || (i == DEPTH - 1 && rdy)) h = i;
      if (h >= 0) begin
        for (int i = h; i > 0; i--) begin mv[i] = mv[i-1]; md[i] = md[i-1]; end
        mv[0] = v; md[0] = d;
        if (v) exp_q.push_back(d);
      end
    end
  endtask

  initial begin
    int bias;
    for (int i = 0; i < DEPTH; i++) begin mv[i] = 1'b0; md[i] = '0; end
    repeat (2) @(posedge clk_8f);

    cycle(0, 0, 32'h0, 1, "reset");
    cycle(0, 1, 32'hDEAD_BEEF, 1, "reset");

    cycle(1, 1, 32'h0102_0304, 1, "delay");
    cycle(1, 1, 32'h0506_0708, 1, "delay");
    repeat (3) cycle(1, 0, 32'h1111_1111, 1, "delay");

    cycle(1, 1, 32'hA000_0001, 0, "stall");
    cycle(1, 1, 32'hA000_0002, 0, "stall");
    repeat (3) cycle(1, 1, 32'hA000_0003, 0, "stall");
    cycle(1, 1, 32'hA000_0003, 1, "full_io");
    for (int k = 4; k < 9; k++) cycle(1, 1, 32'hA000_0000 + 32'(k), 1, "full_io");
    repeat (3) cycle(1, 0, 32'h0, 1, "drain");

    cycle(1, 1, 32'hB000_000A, 0, "bubble");
    cycle(1, 0, 32'h5555_5555, 0, "bubble");
    cycle(1, 1, 32'hB000_000B, 0, "bubble");
    cycle(1, 0, 32'h6666_6666, 0, "bubble");
    repeat (3) cycle(1, 0, 32'h0, 1, "bubble");

    cycle(1, 1, 32'hC000_0001, 0, "mid_rst");
    cycle(1, 1, 32'hC000_0002, 0, "mid_rst");
    cycle(0, 0, 32'h0, 0, "mid_rst");
    cycle(0, 0, 32'h0, 1, "mid_rst");
    repeat (3) cycle(1, 0, 32'h0, 1, "mid_rst");

    for (int n = 0; n < 1500; n++) begin
      bias = ((n / 250) % 2 != 0) ? 30 : 85;
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, $urandom,
            $urandom_range(0, 99) < bias, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
